// File: rtl/uart_frame_rx.sv
// uart_frame_rx: SOF/LEN/payload/XOR-checksum framer that releases only verified payloads
module uart_frame_rx #(
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [15:0] ok_cnt,
  output logic [15:0] err_cnt
);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [7:0] SOF = 8'hA5;
  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHK, OUT} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] last_q, last_d, wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [7:0] chk_q, chk_d;
  logic [TW-1:0] idle_q, idle_d;
  logic frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
  logic [15:0] ok_cnt_q, ok_cnt_d, err_cnt_q, err_cnt_d;
  logic [7:0] mem_q [MAX_LEN];
  logic acc, wr_en, in_frame;
  assign in_ready = state_q != OUT;
  assign acc = in_valid && in_ready;
  assign in_frame = state_q == LEN || state_q == PAYLOAD || state_q == CHK;
  assign m_valid = state_q == OUT;
  assign m_data = m_valid ? mem_q[rd_idx_q] : 8'h00;
  assign m_last = m_valid && rd_idx_q == last_q;
  assign frame_ok = frame_ok_q;
  assign frame_err = frame_err_q;
  assign ok_cnt = ok_cnt_q;
  assign err_cnt = err_cnt_q;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    chk_d = chk_q;
    frame_ok_d = 1'b0;
    frame_err_d = 1'b0;
    wr_en = 1'b0;
    case (state_q)
      IDLE: state_d = (acc && in_data == SOF) ? LEN : IDLE;
      LEN: if (acc) begin
        if (in_data == 8'd0 || int'(in_data) > MAX_LEN) begin
          frame_err_d = 1'b1;
          state_d = IDLE;
        end else begin
          last_d = IW'(in_data - 8'd1);
          chk_d = in_data;
          wr_idx_d = '0;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: if (acc) begin
        wr_en = 1'b1;
        chk_d = chk_q ^ in_data;
        wr_idx_d = wr_idx_q + IW'(1);
        state_d = (wr_idx_q == last_q) ? CHK : PAYLOAD;
      end
      CHK: if (acc) begin
        frame_ok_d = in_data == chk_q;
        frame_err_d = in_data != chk_q;
        rd_idx_d = '0;
        state_d = (in_data == chk_q) ? OUT : IDLE;
      end
      OUT: if (m_ready) begin
        rd_idx_d = rd_idx_q + IW'(1);
        state_d = (rd_idx_q == last_q) ? IDLE : OUT;
      end
      default: state_d = IDLE;
    endcase
    if (in_frame && !acc && idle_q == TW'(TIMEOUT_CYC - 1)) begin
      frame_err_d = 1'b1;
      state_d = IDLE;
    end
    idle_d = (acc || state_d == IDLE) ? '0 : idle_q + TW'(1);
    ok_cnt_d = (frame_ok_d && ok_cnt_q != 16'hFFFF) ? ok_cnt_q + 16'd1 : ok_cnt_q;
    err_cnt_d = (frame_err_d && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      chk_q <= '0;
      idle_q <= '0;
      frame_ok_q <= 1'b0;
      frame_err_q <= 1'b0;
      ok_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      chk_q <= chk_d;
      idle_q <= idle_d;
      frame_ok_q <= frame_ok_d;
      frame_err_q <= frame_err_d;
      ok_cnt_q <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx_q] <= in_data;
  end
endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed and randomized checks of uart_frame_rx against a byte-level frame parser
module tb_uart_frame_rx;
  localparam int ML = 16;
  localparam int TO = 8;
  logic clk = 0, rst = 1;
  logic [7:0] in_data = 0;
  logic in_valid = 0, in_ready;
  logic [7:0] m_data;
  logic m_valid, m_ready = 1, m_last, frame_ok, frame_err;
  logic [15:0] ok_cnt, err_cnt;
  uart_frame_rx #(.MAX_LEN(ML), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .frame_ok(frame_ok), .frame_err(frame_err), .ok_cnt(ok_cnt), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {logic [7:0] b; int gap;} ev_t;
  ev_t evq[$];
  logic [8:0] got_q[$], exp_q[$];
  int stamp_q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, rdy_mode = 0;
  int ok_pulses = 0, err_pulses = 0, exp_ok = 0, exp_err = 0;
  logic prev_stall = 0;
  logic [8:0] prev_out = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    m_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : (cyc % 4 == 0 || cyc % 4 == 3);
  end
  always @(negedge clk) begin
    if (rst) prev_stall = 0;
    else begin
      if (frame_ok || frame_err) check("ok_err_exclusive", frame_ok && frame_err, 0);
      if (frame_ok) begin
        ok_pulses++;
        check("mvalid_with_ok", m_valid, 1);
      end
      if (frame_err) err_pulses++;
      if (m_valid) check("inready_low_in_out", in_ready, 0);
      if (prev_stall) check("stall_stable", {m_valid, m_last, m_data}, {1'b1, prev_out});
      if (m_valid && m_ready) begin
        got_q.push_back({m_last, m_data});
        stamp_q.push_back(cyc);
      end
      prev_stall = m_valid && !m_ready;
      prev_out = {m_last, m_data};
    end
  end
  function automatic void add(input logic [7:0] b, input int gap);
    evq.push_back('{b, gap});
  endfunction
  function automatic int g(input bit stall);
    if (stall) return TO + $urandom_range(0, 3);
    return ($urandom_range(0, 7) == 0) ? TO - 1 : $urandom_range(0, 2);
  endfunction
  function automatic void add_frame(input int len, input bit corrupt, input int stall_at);
    logic [7:0] x, d;
    x = 8'(len);
    add(8'hA5, g(0));
    add(8'(len), g(stall_at == 1));
    for (int j = 0; j < len; j++) begin
      d = 8'($urandom);
      x ^= d;
      add(d, g(stall_at == j + 2));
    end
    add(corrupt ? x ^ 8'h01 : x, g(stall_at == len + 2));
  endfunction
  function automatic void run_model();
    int i;
    i = 0;
    exp_q.delete();
    exp_ok = 0;
    exp_err = 0;
    while (i < evq.size()) begin
      if (evq[i].b != 8'hA5) i++;
      else begin
        int len, k;
        logic [7:0] x;
        logic [7:0] pl[$];
        len = 0;
        x = 0;
        pl.delete();
        for (int p = 1; p < 300; p++) begin
          k = i + p;
          if (k >= evq.size() || evq[k].gap >= TO) begin
            exp_err++;
            i = k;
            break;
          end
          if (p == 1) begin
            len = evq[k].b;
            x = evq[k].b;
            if (len == 0 || len > ML) begin
              exp_err++;
              i = k + 1;
              break;
            end
          end else if (p <= len + 1) begin
            x ^= evq[k].b;
            pl.push_back(evq[k].b);
          end else begin
            if (evq[k].b == x) begin
              exp_ok++;
              foreach (pl[j]) exp_q.push_back({j == pl.size() - 1, pl[j]});
            end else exp_err++;
            i = k + 1;
            break;
          end
        end
      end
    end
  endfunction
  task automatic send(input logic [7:0] b, input int gap);
    int w;
    w = 0;
    in_valid = 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1;
    in_data = b;
    while (!in_ready && w < 1000) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 1000) check("in_ready_wait", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    in_valid = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("rst_in_ready", in_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_frame_ok", frame_ok, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_ok_cnt", ok_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst = 0;
    evq.delete();
    got_q.delete();
    stamp_q.delete();
    ok_pulses = 0;
    err_pulses = 0;
  endtask
  task automatic settle();
    int quiet, w;
    quiet = 0;
    w = 0;
    in_valid = 0;
    while (quiet <= TO + 2 && w < 3000) begin
      @(posedge clk);
      #1;
      w++;
      quiet = m_valid ? 0 : quiet + 1;
    end
    if (w >= 3000) check("drain_budget", 0, 1);
  endtask
  task automatic play(input string tag);
    foreach (evq[i]) send(evq[i].b, evq[i].gap);
    settle();
    run_model();
    check({tag, "_nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check({tag, "_byte"}, got_q[i], exp_q[i]);
    check({tag, "_ok_cnt"}, ok_cnt, exp_ok);
    check({tag, "_err_cnt"}, err_cnt, exp_err);
    check({tag, "_ok_pulses"}, ok_pulses, exp_ok);
    check({tag, "_err_pulses"}, err_pulses, exp_err);
  endtask
  initial begin
    int n, r, len;
    do_reset();
    rdy_mode = 0;
    add(8'hA5, 0); add(8'h03, 0); add(8'h11, 0); add(8'h22, 0); add(8'h33, 0); add(8'h03, 0);
    play("good");
    for (int i = 1; i < stamp_q.size(); i++) check("good_consecutive", stamp_q[i] - stamp_q[i-1], 1);
    do_reset();
    add(8'hA5, 0); add(8'h02, 0); add(8'hAA, 0); add(8'h55, 0); add(8'h00, 0);
    add(8'hA5, 1); add(8'h01, 0); add(8'h42, 0); add(8'h43, 0);
    play("badchk");
    do_reset();
    add(8'hA5, 0); add(8'h00, 0); add(8'hA5, 0); add(8'(ML + 1), 0);
    add_frame(ML, 0, -1);
    play("lenerr");
    do_reset();
    rdy_mode = 2;
    add(8'hA5, 0); add(8'h04, 0); add(8'hDE, 0); add(8'hAD, 0); add(8'hBE, 0); add(8'hEF, 0);
    add(8'h04 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF, 0);
    add(8'h12, 0);
    add_frame(3, 0, -1);
    play("backpressure");
    rdy_mode = 0;
    do_reset();
    send(8'hA5, 0); send(8'h02, 0); send(8'h11, 0);
    n = 0;
    for (int t = 1; t <= 20; t++) begin
      @(posedge clk);
      #1;
      if (frame_err) begin
        n = t;
        break;
      end
    end
    check("timeout_cycles", n, TO);
    check("timeout_err_cnt", err_cnt, 1);
    do_reset();
    add(8'hA5, 0); add(8'h02, 0); add(8'h11, 0); add(8'h22, TO - 1); add(8'h02 ^ 8'h11 ^ 8'h22, 0);
    play("boundary");
    do_reset();
    add(8'h00, 0); add(8'hFF, 0); add(8'h12, 0);
    add_frame(5, 0, -1);
    play("garbage");
    do_reset();
    send(8'hA5, 0); send(8'h04, 0); send(8'h01, 0); send(8'h02, 0);
    do_reset();
    add_frame(4, 0, -1);
    play("after_rst");
    rdy_mode = 1;
    for (int round = 0; round < 6; round++) begin
      do_reset();
      for (int k = 0; k < 25; k++) begin
        r = $urandom_range(0, 9);
        if (r <= 5) add_frame($urandom_range(1, ML), 0, -1);
        else if (r == 6) add_frame($urandom_range(1, ML), 1, -1);
        else if (r == 7) begin
          add(8'hA5, g(0));
          add($urandom_range(0, 1) ? 8'h00 : 8'($urandom_range(ML + 1, 255)), g(0));
        end else if (r == 8) repeat ($urandom_range(1, 3)) add(8'($urandom), g(0));
        else begin
          len = $urandom_range(1, ML);
          add_frame(len, 0, $urandom_range(1, len + 2));
        end
      end
      play("random");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Framing stage directly downstream of `uart_rx`. It consumes the received byte stream and recognises frames of the form SOF (0xA5), LEN, LEN payload bytes, CHK. Each payload is buffered until its checksum is verified. Only verified payloads are released on a byte stream with a last-byte marker, toward the NoC-side command logic. Malformed, corrupted and stalled frames are dropped and counted.

## Interface
- `MAX_LEN`, 16: maximum payload length in bytes; legal range 1..255.
- `TIMEOUT_CYC`, 50000: allowed clk cycles between accepted bytes inside a frame; must be ≥ 2.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_data` in 8: received byte (connects to `uart_rx` rx_data).
- `in_valid` in 1: byte available (connects to rx_data_valid).
- `in_ready` out 1: byte consumed (connects to rx_data_ready).
- `m_data` out 8: payload byte.
- `m_valid` out 1: `m_data` valid.
- `m_ready` in 1: downstream accepts the byte.
- `m_last` out 1: the current byte is the final payload byte.
- `frame_ok` out 1: one-cycle pulse when a frame's checksum passes.
- `frame_err` out 1: one-cycle pulse when a frame is dropped.
- `ok_cnt` out 16: count of good frames, saturating at 0xFFFF.
- `err_cnt` out 16: count of dropped frames, saturating at 0xFFFF.

## Operation
- An input byte is accepted when `in_valid && in_ready`.
- `in_ready` = 1 in IDLE, LEN, PAYLOAD and CHK; `in_ready` = 0 in OUT.
- The checksum is the 8-bit XOR of LEN and all payload bytes.
- State IDLE:
  - An accepted byte of 0xA5 moves to LEN.
  - Any other accepted byte is discarded silently; nothing is counted.
- State LEN:
  - If the accepted byte is 0 or greater than `MAX_LEN`: pulse `frame_err`, increment `err_cnt`, go to IDLE.
  - Otherwise: store len, set chk = byte, set wr_idx = 0, go to PAYLOAD.
- State PAYLOAD:
  - Each accepted byte is written to buf[wr_idx], and chk ^= byte.
  - The byte accepted when wr_idx == len-1 moves the block to CHK. Otherwise wr_idx increments.
  - A payload byte equal to 0xA5 is ordinary data; there is no resynchronisation.
- State CHK:
  - If the accepted byte == chk: pulse `frame_ok`, increment `ok_cnt`, set rd_idx = 0, go to OUT.
  - Otherwise: pulse `frame_err`, increment `err_cnt`, go to IDLE.
- State OUT:
  - `m_valid` = 1 and `m_data` = buf[rd_idx].
  - `m_last` = (rd_idx == len-1).
  - On `m_valid && m_ready`, rd_idx increments.
  - A handshake on the byte with `m_last` = 1 returns the block to IDLE.
  - `m_data` and `m_last` stay stable while `m_valid && !m_ready`.
- Timeout, in LEN, PAYLOAD and CHK:
  - The idle counter clears on every accepted byte and on entry to IDLE. It increments on every other cycle.
  - If the counter reaches `TIMEOUT_CYC`-1 in a cycle with no accepted byte: pulse `frame_err`, increment `err_cnt`, go to IDLE.
  - If a byte is accepted in that same cycle, the byte wins and the timeout does not fire.
- There is no timeout in IDLE or OUT. OUT waits on `m_ready` indefinitely.
- Counter widths: wr_idx and rd_idx are $clog2(`MAX_LEN`) bits, minimum 1. The idle counter is $clog2(`TIMEOUT_CYC`) bits.
- Buffer: `MAX_LEN` x 8, with a registered or combinational read. `m_data` must be valid in the same cycle `m_valid` is high.

## Timing
- Reset values:
  - State = IDLE, `in_ready` = 1.
  - `m_valid` = 0, `m_last` = 0, `m_data` = 0x00.
  - `frame_ok` = 0, `frame_err` = 0, `ok_cnt` = 0, `err_cnt` = 0.
  - Buffer contents are don't-care.
- Reset mid-frame or mid-OUT discards the frame. Counters clear and no pulse is generated.
- `frame_ok` is asserted in the cycle after the CHK byte is accepted. `m_valid` rises in that same cycle.
- `frame_err` is asserted in the cycle after the offending byte, or in the cycle after the timeout condition.
- `in_ready` falls in the cycle after the good CHK byte. It rises in the cycle after the last output handshake.
- Best-case throughput in OUT is 1 byte per cycle with `m_ready` held high, so a LEN=N frame drains in N cycles.
- `frame_ok` and `frame_err` are never high in the same cycle.
- Counter saturation: at 0xFFFF an increment leaves the counter at 0xFFFF.

## Test plan
- Good frame: feed A5 03 11 22 33 with CHK 03^11^22^33 = 0x03, `m_ready`=1 -> one `frame_ok` pulse, then `m_data` 11, 22, 33 on consecutive cycles, with `m_last` high only on 33; `ok_cnt`=1.
- Bad checksum: feed A5 02 AA 55 with CHK 0x00 (correct value is 0xFD) -> one `frame_err` pulse, `m_valid` never high, `err_cnt`=1, block back in IDLE; a following good frame passes.
- Length errors: feed A5 00 and then A5 with LEN = `MAX_LEN`+1 -> two `frame_err` pulses, `err_cnt`=2. Feed a frame with LEN = `MAX_LEN` -> all 16 bytes output, `m_last` on the 16th.
- Backpressure: good frame with LEN=4 while `m_ready` toggles 1,0,0,1,... -> bytes are output in order with data stable while stalled; `in_ready`=0 for the whole of OUT; `in_valid` bytes presented during OUT stay unconsumed.
- Timeout and boundary: with `TIMEOUT_CYC`=8, feed A5 02 11 then stall -> `frame_err` exactly 8 cycles after the 11 is accepted. Repeat with the next byte arriving on cycle 8 -> no timeout.
- Garbage and reset: feed 00 FF 12 then a good frame -> only the good frame is output and `err_cnt`=0. Assert `rst` mid-PAYLOAD -> all outputs return to reset values and the next frame is parsed correctly.
